// File: rtl/cache_bus_if.sv
// Native cache burst bus: read request/return, write request/data/response.
// The cache is the master; the memory-side responder is the slave.
interface cache_bus_if;
    logic        r_req;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_length;
    logic        r_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] r_data;
    logic        r_data_ready;
    logic        w_req;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [7:0]  w_length;
    logic        w_rdy;
    logic        w_data_req;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_data_ready;
    logic        b_valid;
    logic        b_ready;
    logic        protocol_err;

    modport master (
        output r_req, r_addr, r_size, r_length, r_data_ready,
        output w_req, w_addr, w_size, w_length, w_data_req, w_data, w_strb, w_last, b_ready,
        input  r_rdy, ret_valid, ret_last, r_data, w_rdy, w_data_ready, b_valid, protocol_err
    );

    modport slave (
        input  r_req, r_addr, r_size, r_length, r_data_ready,
        input  w_req, w_addr, w_size, w_length, w_data_req, w_data, w_strb, w_last, b_ready,
        output r_rdy, ret_valid, ret_last, r_data, w_rdy, w_data_ready, b_valid, protocol_err
    );
endinterface

// File: rtl/cache_bus_responder.sv
// Behavioural memory responder for the cache burst bus: one transaction at a time,
// word-addressed byte-lane array, INCR bursts wrapping modulo the array depth.
module cache_bus_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    cache_bus_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, R_WAIT, R_BURST, W_DATA, W_RESP} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic [8:0]            remain_reg, remain_next;
    logic [7:0]            wait_reg, wait_next;
    logic                  err_reg, err_next;
    logic [2:0]            size_reg, size_next;
    logic                  mem_we;
    logic [31:0]           rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            remain_reg <= '0;
            wait_reg   <= '0;
            err_reg    <= 1'b0;
            size_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            remain_reg <= remain_next;
            wait_reg   <= wait_next;
            err_reg    <= err_next;
            size_reg   <= size_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        remain_next = remain_reg;
        wait_next   = wait_reg;
        err_next    = err_reg;
        size_next   = size_reg;
        mem_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Write wins when both requests are present.
                if (bus.w_req) begin
                    idx_next    = bus.w_addr[ADDR_WIDTH+1:2];
                    remain_next = {1'b0, bus.w_length} + 9'd1;
                    size_next   = bus.w_size;
                    state_next  = W_DATA;
                end else if (bus.r_req) begin
                    idx_next    = bus.r_addr[ADDR_WIDTH+1:2];
                    remain_next = {1'b0, bus.r_length} + 9'd1;
                    size_next   = bus.r_size;
                    wait_next   = 8'(RD_LATENCY);
                    state_next  = (RD_LATENCY == 0) ? R_BURST : R_WAIT;
                end
            end
            R_WAIT: begin
                if (wait_reg <= 8'd1) begin
                    wait_next  = '0;
                    state_next = R_BURST;
                end else begin
                    wait_next = wait_reg - 8'd1;
                end
            end
            R_BURST: begin
                if (bus.r_data_ready) begin
                    if (remain_reg == 9'd1) begin
                        remain_next = '0;
                        state_next  = IDLE;
                    end else begin
                        idx_next    = idx_reg + 1'b1;
                        remain_next = remain_reg - 9'd1;
                    end
                end
            end
            W_DATA: begin
                if (bus.w_data_req) begin
                    // Beats beyond the announced length are dropped and flagged.
                    if (remain_reg != 9'd0) begin
                        mem_we      = 1'b1;
                        idx_next    = idx_reg + 1'b1;
                        remain_next = remain_reg - 9'd1;
                    end else begin
                        err_next = 1'b1;
                    end
                    if (bus.w_last) begin
                        if (remain_reg > 9'd1) err_next = 1'b1;
                        state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bus.b_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read port always fetches the word that will be presented next cycle,
    // so a stalled beat simply re-reads the same index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q_reg;
        always_ff @(posedge clk) begin
            if (mem_we && bus.w_strb[gi]) lane_mem[idx_reg] <= bus.w_data[8*gi +: 8];
            lane_q_reg <= lane_mem[idx_next];
        end
        assign rd_word[8*gi +: 8] = lane_q_reg;
    end

    assign bus.w_rdy        = (state_reg == IDLE) && !rst;
    assign bus.r_rdy        = (state_reg == IDLE) && !rst && !bus.w_req;
    assign bus.ret_valid    = (state_reg == R_BURST);
    assign bus.ret_last     = (state_reg == R_BURST) && (remain_reg == 9'd1);
    assign bus.r_data       = (state_reg == R_BURST) ? rd_word : 32'd0;
    assign bus.w_data_ready = (state_reg == W_DATA);
    assign bus.b_valid      = (state_reg == W_RESP);
    assign bus.protocol_err = err_reg;

    logic unused_bits;
    assign unused_bits = ^{size_reg, bus.r_addr[31:ADDR_WIDTH+2], bus.r_addr[1:0],
                           bus.w_addr[31:ADDR_WIDTH+2], bus.w_addr[1:0]};
endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder: stimulus pushes expected beats/responses
// into queues, a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_cache_bus_responder;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_bus_if bus();

    cache_bus_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t rd_q[$];
    logic  b_q[$];
    beat_t mon_beat;
    logic  mon_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.ret_valid && bus.r_data_ready) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected_beat", 32'd1, 32'd0);
            end else begin
                mon_beat = rd_q.pop_front();
                check("rd_data", bus.r_data, mon_beat.data);
                check("rd_last", 32'(bus.ret_last), 32'(mon_beat.last));
                $display("read beat data=0x%08h last=%0d", bus.r_data, bus.ret_last);
            end
        end
        if (bus.b_valid && bus.b_ready) begin
            if (b_q.size() == 0) begin
                check("b_unexpected", 32'd1, 32'd0);
            end else begin
                mon_err = b_q.pop_front();
                check("b_protocol_err", 32'(bus.protocol_err), 32'(mon_err));
                $display("write response protocol_err=%0d", bus.protocol_err);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_r_rdy"},        32'(bus.r_rdy),        32'd0);
        check({tag, "_w_rdy"},        32'(bus.w_rdy),        32'd0);
        check({tag, "_ret_valid"},    32'(bus.ret_valid),    32'd0);
        check({tag, "_ret_last"},     32'(bus.ret_last),     32'd0);
        check({tag, "_r_data"},       bus.r_data,            32'd0);
        check({tag, "_w_data_ready"}, 32'(bus.w_data_ready), 32'd0);
        check({tag, "_b_valid"},      32'(bus.b_valid),      32'd0);
        check({tag, "_protocol_err"}, 32'(bus.protocol_err), 32'd0);
    endtask

    task automatic read_push(input logic [31:0] base, input int len);
        for (int i = 0; i <= len; i++) rd_q.push_back('{data: base + 32'(i), last: (i == len)});
    endtask

    // Called at posedge+1 with r_req already driven; returns at posedge+1 after the accept edge.
    task automatic wait_r_rdy(output int waited);
        waited = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.r_rdy) begin
                waited = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (waited < 0) check("r_rdy_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.r_req = 1'b0;
    endtask

    task automatic read_issue(input logic [31:0] addr, input int len);
        int waited;
        bus.r_req    = 1'b1;
        bus.r_addr   = addr;
        bus.r_length = 8'(len);
        bus.r_size   = 3'd2;
        wait_r_rdy(waited);
        $display("read request addr=0x%08h beats=%0d", addr, len + 1);
    endtask

    task automatic read_drain(input int len, input int stall_beat, input int rst_beat);
        int beats = 0;
        int cyc   = 0;
        int stall = 0;
        int first = -1;
        logic [31:0] held = '0;
        while (beats <= len && cyc < 300) begin
            if (beats == rst_beat) begin
                bus.r_data_ready = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                check_all_zero("midrst");
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_w_rdy", 32'(bus.w_rdy), 32'd1);
                check("post_rst_r_rdy", 32'(bus.r_rdy), 32'd1);
                @(posedge clk); #1;
                rd_q.delete();
                $display("reset applied during read beat %0d", rst_beat + 1);
                return;
            end
            bus.r_data_ready = !(beats == stall_beat && stall < 3);
            @(negedge clk);
            cyc++;
            if (bus.ret_valid && first < 0) begin
                first = cyc;
                check("rd_first_beat_cycle", 32'(cyc), 32'(LAT + 1));
            end
            if (!bus.r_data_ready) begin
                stall++;
                check("rd_stall_valid", 32'(bus.ret_valid), 32'd1);
                if (stall == 1) held = bus.r_data;
                else check("rd_stall_data_stable", bus.r_data, held);
            end
            if (bus.ret_valid && bus.r_data_ready) beats++;
            @(posedge clk); #1;
        end
        bus.r_data_ready = 1'b0;
        if (beats <= len) check("rd_beat_timeout", 32'(beats), 32'(len + 1));
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input int nsent,
                               input logic [31:0] base, input logic [3:0] strb,
                               input logic exp_err, input logic arb);
        int waited = -1;
        b_q.push_back(exp_err);
        bus.w_req    = 1'b1;
        bus.w_addr   = addr;
        bus.w_length = 8'(len);
        bus.w_size   = 3'd2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arb && i == 0) begin
                check("arb_w_rdy_high", 32'(bus.w_rdy), 32'd1);
                check("arb_r_rdy_low",  32'(bus.r_rdy), 32'd0);
            end
            if (bus.w_rdy) begin
                waited = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (waited < 0) check("w_rdy_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.w_req = 1'b0;
        for (int i = 0; i < nsent; i++) begin
            bus.w_data_req = 1'b1;
            bus.w_data     = base + 32'(i);
            bus.w_strb     = strb;
            bus.w_last     = (i == nsent - 1);
            @(negedge clk);
            if (i == 0) check("w_data_ready", 32'(bus.w_data_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.w_data_req = 1'b0;
        bus.w_last     = 1'b0;
        @(negedge clk);
        check("b_valid_after_last", 32'(bus.b_valid), 32'd1);
        @(posedge clk); #1;
        bus.b_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        $display("write addr=0x%08h length=%0d beats_sent=%0d strb=%b", addr, len, nsent, strb);
    endtask

    initial begin
        int waited;
        bus.r_req = 0; bus.r_addr = 0; bus.r_size = 0; bus.r_length = 0; bus.r_data_ready = 0;
        bus.w_req = 0; bus.w_addr = 0; bus.w_size = 0; bus.w_length = 0;
        bus.w_data_req = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_w_rdy", 32'(bus.w_rdy), 32'd1);
        check("rst_release_r_rdy", 32'(bus.r_rdy), 32'd1);
        @(posedge clk); #1;

        // Burst round trip
        write_burst(32'h1C00_0040, 15, 16, 32'h100, 4'hF, 1'b0, 1'b0);
        read_push(32'h100, 15);
        read_issue(32'h1C00_0040, 15);
        read_drain(15, -1, -1);

        // Byte strobes
        write_burst(32'h200, 0, 1, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        write_burst(32'h200, 0, 1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
        read_push(32'h11BB_33DD, 0);
        read_issue(32'h200, 0);
        read_drain(0, -1, -1);

        // Read backpressure on beat 5
        read_push(32'h100, 15);
        read_issue(32'h1C00_0040, 15);
        read_drain(15, 4, -1);

        // Arbitration: read and write raised together
        read_push(32'h3000, 3);
        bus.r_req    = 1'b1;
        bus.r_addr   = 32'h300;
        bus.r_length = 8'd3;
        bus.r_size   = 3'd2;
        write_burst(32'h300, 3, 4, 32'h3000, 4'hF, 1'b0, 1'b1);
        wait_r_rdy(waited);
        check("arb_read_accept_delay", 32'(waited), 32'd0);
        read_drain(3, -1, -1);

        // Wrap from the last word index
        write_burst(32'h5A5A_7FFF, 3, 4, 32'h700, 4'hF, 1'b0, 1'b0);
        read_push(32'h701, 2);
        read_issue(32'h0, 2);
        read_drain(2, -1, -1);
        read_push(32'h700, 3);
        read_issue(32'h3FFC, 3);
        read_drain(3, -1, -1);

        // Early w_last
        write_burst(32'h600, 15, 4, 32'h600, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        check("protocol_err_sticky", 32'(bus.protocol_err), 32'd1);
        @(posedge clk); #1;

        // Reset during beat 6, then data survives
        read_push(32'h100, 15);
        read_issue(32'h1C00_0040, 15);
        read_drain(15, -1, 5);
        read_push(32'h100, 15);
        read_issue(32'h1C00_0040, 15);
        read_drain(15, -1, -1);

        // Overrun beats are dropped
        write_burst(32'h500, 2, 3, 32'hDEAD_0000, 4'hF, 1'b0, 1'b0);
        write_burst(32'h500, 1, 3, 32'h5000, 4'hF, 1'b1, 1'b0);
        rd_q.push_back('{data: 32'h0000_5000, last: 1'b0});
        rd_q.push_back('{data: 32'h0000_5001, last: 1'b0});
        rd_q.push_back('{data: 32'hDEAD_0002, last: 1'b1});
        read_issue(32'h500, 2);
        read_drain(2, -1, -1);

        repeat (2) @(posedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("b_queue_drained",  32'(b_q.size()),  32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
